// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: writeback destinations, SC bit layout, ALU flag indices
package cpu_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_REG  = 2'd1,
    WB_MEM  = 2'd2,
    WB_RSVD = 2'd3
  } wb_dest_e;

  // ALU flag bit N lands in SC bit N, so these indices line up with SC_Z..SC_N
  typedef enum int {
    FLAG_Z = 0,
    FLAG_C = 1,
    FLAG_V = 2,
    FLAG_S = 3
  } alu_flag_e;

  localparam int SC_Z  = 0;
  localparam int SC_C  = 1;
  localparam int SC_V  = 2;
  localparam int SC_N  = 3;
  localparam int SC_D  = 4;
  localparam int SC_U  = 5;
  localparam int SC_I0 = 6;
  localparam int SC_I1 = 7;

  localparam logic [7:0] SC_RESET_DEFAULT = 8'hC0;

  function automatic logic [3:0] merge_flags(logic [3:0] cur, logic [3:0] flags, logic [3:0] mask);
    return (cur & ~mask) | (flags & mask);
  endfunction

endpackage

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result commit to register file or byte bus, SC flag merge
// Optional: ALU_WB_BUS_TIMEOUT_EN adds a 255-cycle bus ack timeout and the bus_err output.
import cpu_pkg::*;

module alu_writeback #(
  parameter int         ADDR_W   = 24,
  parameter int         REG_ID_W = 4,
  parameter logic [7:0] SC_RESET = SC_RESET_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_dest,
  input  logic                in_size,
  input  logic [15:0]         in_result,
  input  logic [3:0]          in_flags,
  input  logic [3:0]          in_flag_mask,
  input  logic [REG_ID_W-1:0] in_reg_id,
  input  logic [ADDR_W-1:0]   in_addr,
  output logic                reg_we,
  output logic [REG_ID_W-1:0] reg_id,
  output logic [15:0]         reg_wdata,
  output logic                reg_wsize,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [7:0]          bus_wdata,
  output logic                bus_write,
  input  logic                bus_ack,
  input  logic                sc_wr,
  input  logic [7:0]          sc_wdata,
  output logic [7:0]          sc,
  output logic                done
`ifdef ALU_WB_BUS_TIMEOUT_EN
  ,
  output logic                bus_err
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEM_LO = 2'd1;
  localparam logic [1:0] MEM_HI = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic       size_q;
  logic [7:0] hi_q;
  logic       accept;

  assign in_ready = (state == IDLE);
  assign done     = (state == FINISH);
  assign accept   = in_valid & in_ready;

`ifdef ALU_WB_BUS_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       timeout_hit;
  // tcnt holds the number of ack-less cycles already spent; this is the 255th
  assign timeout_hit = (tcnt == 8'd254);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      size_q    <= 1'b0;
      hi_q      <= 8'h00;
      sc        <= SC_RESET;
      reg_we    <= 1'b0;
      reg_id    <= '0;
      reg_wdata <= 16'h0000;
      reg_wsize <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      bus_write <= 1'b0;
`ifdef ALU_WB_BUS_TIMEOUT_EN
      tcnt      <= 8'h00;
      bus_err   <= 1'b0;
`endif
    end else begin
      reg_we <= 1'b0;
`ifdef ALU_WB_BUS_TIMEOUT_EN
      bus_err <= 1'b0;
`endif

      // A direct SC write overrides the accept-edge merge for all eight bits
      if (sc_wr) begin
        sc <= sc_wdata;
      end else if (accept) begin
        sc <= {sc[7:4], merge_flags(sc[3:0], in_flags, in_flag_mask)};
      end

      case (state)
        IDLE: begin
          if (accept) begin
            size_q <= in_size;
            hi_q   <= in_result[15:8];
            case (in_dest)
              WB_REG: begin
                reg_we    <= 1'b1;
                reg_id    <= in_reg_id;
                reg_wdata <= in_result;
                reg_wsize <= in_size;
                state     <= FINISH;
              end
              WB_MEM: begin
                bus_write <= 1'b1;
                bus_addr  <= in_addr;
                bus_wdata <= in_result[7:0];
                state     <= MEM_LO;
`ifdef ALU_WB_BUS_TIMEOUT_EN
                tcnt      <= 8'h00;
`endif
              end
              default: state <= FINISH;
            endcase
          end
        end

        MEM_LO: begin
          if (bus_ack) begin
`ifdef ALU_WB_BUS_TIMEOUT_EN
            tcnt <= 8'h00;
`endif
            if (size_q) begin
              bus_addr  <= bus_addr + ADDR_ONE;
              bus_wdata <= hi_q;
              state     <= MEM_HI;
            end else begin
              bus_write <= 1'b0;
              state     <= FINISH;
            end
          end
`ifdef ALU_WB_BUS_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_write <= 1'b0;
            bus_err   <= 1'b1;
            state     <= FINISH;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end

        MEM_HI: begin
          if (bus_ack) begin
            bus_write <= 1'b0;
            state     <= FINISH;
`ifdef ALU_WB_BUS_TIMEOUT_EN
            tcnt      <= 8'h00;
`endif
          end
`ifdef ALU_WB_BUS_TIMEOUT_EN
          else if (timeout_hit) begin
            bus_write <= 1'b0;
            bus_err   <= 1'b1;
            state     <= FINISH;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - scoreboard bench for alu_writeback (default build)
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_dest = 2'd0;
  logic        in_size = 1'b0;
  logic [15:0] in_result = 16'h0;
  logic [3:0]  in_flags = 4'h0;
  logic [3:0]  in_flag_mask = 4'h0;
  logic [3:0]  in_reg_id = 4'h0;
  logic [23:0] in_addr = 24'h0;
  logic        reg_we;
  logic [3:0]  reg_id;
  logic [15:0] reg_wdata;
  logic        reg_wsize;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_write;
  logic        bus_ack = 1'b0;
  logic        sc_wr = 1'b0;
  logic [7:0]  sc_wdata = 8'h0;
  logic [7:0]  sc;
  logic        done;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_size(in_size), .in_result(in_result), .in_flags(in_flags),
    .in_flag_mask(in_flag_mask), .in_reg_id(in_reg_id), .in_addr(in_addr),
    .reg_we(reg_we), .reg_id(reg_id), .reg_wdata(reg_wdata), .reg_wsize(reg_wsize),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write), .bus_ack(bus_ack),
    .sc_wr(sc_wr), .sc_wdata(sc_wdata), .sc(sc), .done(done)
  );

  localparam int EV_REG  = 0;
  localparam int EV_BUS  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic got_ev(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", kind, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_addr", a, e.a);
      check("ev_data", d, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (reg_we) got_ev(EV_REG, {28'h0, reg_id}, {15'h0, reg_wsize, reg_wdata});
      if (bus_write && bus_ack) got_ev(EV_BUS, {8'h0, bus_addr}, {24'h0, bus_wdata});
      if (done) got_ev(EV_DONE, 32'h0, 32'h0);
    end
  end

  task automatic send(input logic [1:0] dest, input logic size, input logic [15:0] res,
                      input logic [3:0] fl, input logic [3:0] mk, input logic [3:0] id,
                      input logic [23:0] addr, input logic swr, input logic [7:0] swd);
    int n = 0;
    logic [23:0] a1;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("ready_timeout", {31'h0, in_ready}, 32'h1);
    in_dest = dest; in_size = size; in_result = res; in_flags = fl;
    in_flag_mask = mk; in_reg_id = id; in_addr = addr;
    sc_wr = swr; sc_wdata = swd; in_valid = 1'b1;
    a1 = addr + 24'd1;
    if (dest == 2'd1) begin
      push(EV_REG, {28'h0, id}, {15'h0, size, res});
    end else if (dest == 2'd2) begin
      push(EV_BUS, {8'h0, addr}, {24'h0, res[7:0]});
      if (size) push(EV_BUS, {8'h0, a1}, {24'h0, res[15:8]});
    end
    push(EV_DONE, 32'h0, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0; sc_wr = 1'b0;
    // scramble inputs: the stage must have captured them on the accept edge
    in_result = 16'($urandom); in_addr = 24'($urandom); in_size = ~size;
    in_reg_id = 4'($urandom); in_flags = 4'($urandom); in_flag_mask = 4'($urandom);
  endtask

  task automatic serve(input int nbytes, input int delay);
    for (int b = 0; b < nbytes; b++) begin
      int n = 0;
      while (!bus_write && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) check("bus_write_timeout", {31'h0, bus_write}, 32'h1);
      for (int k = 0; k < delay; k++) begin
        @(posedge clk); #1;
        check("busy_in_ready", {31'h0, in_ready}, 32'h0);
      end
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
  endtask

  task automatic set_sc(input logic [7:0] v);
    @(posedge clk); #1; sc_wr = 1'b1; sc_wdata = v;
    @(posedge clk); #1; sc_wr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_sc", {24'h0, sc}, 32'hC0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_bus_write", {31'h0, bus_write}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_bus_addr", {8'h0, bus_addr}, 32'h0);
    reset_n = 1'b1;

    // register word write, one-cycle latency
    send(2'd1, 1'b1, 16'hBEEF, 4'b0010, 4'hF, 4'd3, 24'h0, 1'b0, 8'h0);
    check("t1_reg_we", {31'h0, reg_we}, 32'h1);
    check("t1_done", {31'h0, done}, 32'h1);
    check("t1_sc", {24'h0, sc}, 32'hC2);

    // byte register write keeps the upper byte of R
    send(2'd1, 1'b0, 16'h7788, 4'hF, 4'h0, 4'd9, 24'h0, 1'b0, 8'h0);
    check("t1b_sc_unmasked", {24'h0, sc}, 32'hC2);

    // word store across the address wrap, ack after 2 cycles per byte
    send(2'd2, 1'b1, 16'h1234, 4'h0, 4'h0, 4'd0, 24'hFFFFFF, 1'b0, 8'h0);
    serve(2, 2);
    check("t2_done_after_ack", {31'h0, done}, 32'h1);
    check("t2_bus_write_drop", {31'h0, bus_write}, 32'h0);

    // partial mask, then direct SC write beating the merge
    set_sc(8'hCF);
    check("t3_sc_load", {24'h0, sc}, 32'hCF);
    send(2'd0, 1'b0, 16'h0, 4'b0000, 4'b0101, 4'd0, 24'h0, 1'b0, 8'h0);
    check("t3_sc_mask", {24'h0, sc}, 32'hCA);
    send(2'd0, 1'b0, 16'h0, 4'hF, 4'hF, 4'd0, 24'h0, 1'b1, 8'h10);
    check("t3_sc_wr_wins", {24'h0, sc}, 32'h10);

    // reserved dest acts like WB_NONE
    send(2'd3, 1'b0, 16'h0, 4'b1000, 4'b1000, 4'd0, 24'h0, 1'b0, 8'h0);
    check("t_rsvd_done", {31'h0, done}, 32'h1);
    check("t_rsvd_sc", {24'h0, sc}, 32'h18);

    // minimum-latency byte store
    send(2'd2, 1'b0, 16'h0001, 4'h0, 4'h0, 4'd0, 24'h000010, 1'b0, 8'h0);
    serve(1, 0);
    check("t_min_lat_done", {31'h0, done}, 32'h1);

    // stray ack while idle, then a byte store
    @(posedge clk); #1;
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("t5_no_done_idle", {31'h0, done}, 32'h0);
    send(2'd2, 1'b0, 16'hAA55, 4'h0, 4'h0, 4'd0, 24'h345678, 1'b0, 8'h0);
    serve(1, 3);
    check("t5_done", {31'h0, done}, 32'h1);

    // reset in the middle of the high-byte store
    send(2'd2, 1'b1, 16'h5AA5, 4'h0, 4'h0, 4'd0, 24'h000100, 1'b0, 8'h0);
    serve(1, 0);
    check("t4_in_mem_hi", {31'h0, bus_write}, 32'h1);
    check("t4_hi_addr", {8'h0, bus_addr}, 32'h101);
    reset_n = 1'b0;
    #1;
    check("t4_bus_write_async", {31'h0, bus_write}, 32'h0);
    check("t4_sc_reset", {24'h0, sc}, 32'hC0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("t4_no_bus", {31'h0, bus_write}, 32'h0);
      check("t4_ready", {31'h0, in_ready}, 32'h1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
